rdmx_xmit: RTL and testbench
============================

# rdmx_xmit

Builds RDMX packets and transmits them on an AXI-Stream bus; it is the sending end of the RDMX link and its packets are decoded by the RDMX receiver at the far end. Each packet is built from two inputs: a command (AXI target address plus burst length) and the matching data beats. The block emits one 64-byte Ethernet/IPv4/UDP/RDMX header beat, then passes the data beats through, asserting TLAST on the final beat. It sits between a local data producer and the Ethernet MAC TX stream.

## Interface
- DATA_WBITS, 512, stream data width; only 512 is supported (header is exactly one beat).
- DATA_WBYTS, DATA_WBITS/8, TKEEP width.
- ADDR_WBITS, 64, target-address width.
- DST_MAC / SRC_MAC, 48'h0 / 48'h0, Ethernet addresses.
- SRC_IP / DST_IP, 32'h0A010101 / 32'h0A010102, IPv4 addresses.
- SRC_PORT / DST_PORT, 16'd32002 / 16'd32002, UDP ports.
- RDMX_MAGIC, 16'h0122, RDMX magic field.

Ports:
- clk  in  1  sole clock.
- resetn  in  1  asynchronous, active-low reset.
- packets_sent  out  64  count of packets completed (TLAST handshakes).
- AXIS_CMD_TDATA  in  72  {beats_minus_1[7:0], target_addr[63:0]}.
- AXIS_CMD_TVALID  in  1  command valid.
- AXIS_CMD_TREADY  out  1  command accepted.
- AXIS_DATA_TDATA  in  DATA_WBITS  payload beat.
- AXIS_DATA_TKEEP  in  DATA_WBYTS  payload byte enables (passed through).
- AXIS_DATA_TVALID  in  1  payload valid.
- AXIS_DATA_TREADY  out  1  payload accepted.
- AXIS_RDMX_TDATA  out  DATA_WBITS  packet stream.
- AXIS_RDMX_TKEEP  out  DATA_WBYTS  all-ones on the header beat; input TKEEP on data beats.
- AXIS_RDMX_TVALID  out  1  packet stream valid.
- AXIS_RDMX_TLAST  out  1  last beat of packet.
- AXIS_RDMX_TREADY  in  1  downstream ready.

## Operation
- States:
  - STARTING: entered on reset; exits to IDLE after one cycle.
  - IDLE: AXIS_CMD_TREADY=1. On a command handshake, latch addr and beats_minus_1 into `len`, load beat counter = `len`, then go to CSUM.
  - CSUM: compute and register the IPv4 checksum, then go to HDR.
  - HDR: drive the header beat with TVALID=1 and TLAST=0. On TREADY, go to DATA.
  - DATA: combinational pass-through.
    - TVALID = AXIS_DATA_TVALID.
    - AXIS_DATA_TREADY = AXIS_RDMX_TREADY.
    - TLAST = (counter==0).
    - Each handshake decrements the counter.
    - On the TLAST handshake, increment packets_sent and go to IDLE.
- AXIS_DATA_TREADY is 0 outside DATA. AXIS_CMD_TREADY is 0 outside IDLE. Input data TLAST does not exist; packet length comes only from the command.
- Header byte layout: byte 0 is TDATA[7:0]. Fields are big-endian, in this order:
  - Ethernet (14 bytes): DST_MAC, SRC_MAC, type 16'h0800.
  - IPv4 (20 bytes): 16'h4500, ip_len, id 16'h0000, flags 16'h4000, ttl/proto 16'h4011, checksum, SRC_IP, DST_IP.
  - UDP (8 bytes): SRC_PORT, DST_PORT, udp_len, checksum 16'h0000.
  - RDMX (22 bytes): RDMX_MAGIC, target_addr (8 bytes), 12 reserved zero bytes.
  - Total: 64 bytes.
- Length arithmetic (16-bit, no overflow possible):
  - udp_len = 30 + 64*(len+1).
  - ip_len = udp_len + 20.
- Checksum: one's-complement sum of the ten IPv4 header words, with the checksum word taken as 0. Fold the carry twice, then invert.

## Timing
- Reset values:
  - AXIS_CMD_TREADY=0, AXIS_DATA_TREADY=0.
  - AXIS_RDMX_TVALID=0, AXIS_RDMX_TLAST=0.
  - packets_sent=0.
  - TDATA/TKEEP: don't-care while TVALID=0.
- Latency: a command handshake in cycle N puts the header TVALID high in cycle N+2.
- Header stability: the header beat holds stable until TREADY is seen (AXIS rule: no TVALID drop, no data change).
- Packet spacing: a TLAST handshake in cycle T allows the next command handshake at the earliest in T+1, and the next header at T+3.
- Input stall: a stalled data input mid-packet drops AXIS_RDMX_TVALID but leaves the state unchanged.
- len=0: the packet is header + 1 beat, with TLAST on that beat.
- len=255: the packet is header + 256 beats.
- Reset mid-packet: outputs return to reset values immediately; the partial packet is abandoned without TLAST, and the downstream is reset with this block.
- Command arriving mid-packet: held (TREADY=0) until IDLE.

## Structure
- Package rdmx_pkg holds:
  - RDMX_HDR_LEN=22 and UDP_HDR_LEN=8;
  - IPv4 constant words (16'h4500, 16'h4000, 16'h4011);
  - ethertype 16'h0800;
  - state encodings;
  - a function ip4_csum(ip_len, src_ip, dst_ip).
- One sub-module: rdmx_hdr_build. It is combinational and maps {addr, len, csum, parameters} to the 512-bit byte-swapped header beat. The main block contains the FSM, counter and checksum register.

## Test plan
- Single packet: default parameters, command {len=0, addr=64'h0000_0001_2345_6780}, data always valid, TREADY=1.
  - Required response: 2 beats, TLAST on beat 2.
  - Header bytes: ip_len=0x0072, udp_len=0x005E, checksum=0x2477, address bytes 01..0x80 in big-endian order.
  - packets_sent=1.
- Maximum length: command with len=255.
  - Required response: 257 beats, udp_len=0x401E, ip_len=0x4032, checksum=0xE4B6.
- Backpressure: toggle TREADY randomly 50% and stall data valid on beats 3–5 of an 8-beat packet.
  - Required response: header and data stay stable while stalled, no beats lost or duplicated, TLAST on beat 9.
- Back-to-back: two commands queued.
  - Required response: second header appears exactly 3 cycles after the first packet's TLAST handshake; packets_sent=2.
- Reset mid-packet: assert resetn=0 during beat 4.
  - Required response: TVALID=0 and both TREADYs=0 in the same cycle, packets_sent=0.
  - After release: a new command produces a correct packet.
- TKEEP pass-through: last data beat with TKEEP=64'h0000_0000_FFFF_FFFF.
  - Required response: it appears unchanged on output; header beat TKEEP is all-ones.

Source files
------------

// File: rtl/rdmx_pkg.sv
// Shared constants, FSM encoding and length/checksum helpers for the RDMX
// transmitter.
package rdmx_pkg;

  localparam int RDMX_HDR_LEN = 22;
  localparam int UDP_HDR_LEN  = 8;
  localparam int IP4_HDR_LEN  = 20;
  localparam int HDR_BYTES    = 64;

  localparam logic [15:0] ETH_TYPE_IPV4   = 16'h0800;
  localparam logic [15:0] IP4_VER_IHL_TOS = 16'h4500;
  localparam logic [15:0] IP4_ID          = 16'h0000;
  localparam logic [15:0] IP4_FLAGS_FRAG  = 16'h4000;
  localparam logic [15:0] IP4_TTL_PROTO   = 16'h4011;
  localparam logic [15:0] UDP_CSUM_NONE   = 16'h0000;

  typedef enum logic [2:0] {
    ST_STARTING = 3'd0,
    ST_IDLE     = 3'd1,
    ST_CSUM     = 3'd2,
    ST_HDR      = 3'd3,
    ST_DATA     = 3'd4
  } state_t;

  // UDP payload is the RDMX header plus (len+1) full 64-byte data beats.
  function automatic logic [15:0] udp_len_of(input logic [7:0] len);
    return 16'(UDP_HDR_LEN + RDMX_HDR_LEN) + {2'b00, len, 6'b000000} + 16'(HDR_BYTES);
  endfunction

  function automatic logic [15:0] ip_len_of(input logic [7:0] len);
    return udp_len_of(len) + 16'(IP4_HDR_LEN);
  endfunction

  function automatic logic [15:0] ip4_csum(input logic [15:0] ip_len,
                                           input logic [31:0] src_ip,
                                           input logic [31:0] dst_ip);
    logic [31:0] sum;
    sum = {16'h0, IP4_VER_IHL_TOS} + {16'h0, ip_len} + {16'h0, IP4_ID}
        + {16'h0, IP4_FLAGS_FRAG} + {16'h0, IP4_TTL_PROTO}
        + {16'h0, src_ip[31:16]} + {16'h0, src_ip[15:0]}
        + {16'h0, dst_ip[31:16]} + {16'h0, dst_ip[15:0]};
    // Second fold absorbs the carry the first fold can produce.
    sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    return ~sum[15:0];
  endfunction

endpackage

// File: rtl/rdmx_xmit_if.sv
// Command, payload and packet AXI-Stream bundle around the RDMX transmitter.
// A beat transfers on a rising edge where TVALID and TREADY are both high;
// once TVALID is raised the source holds it and its payload until TREADY.
interface rdmx_xmit_if #(
  parameter int DATA_WBITS = 512,
  parameter int ADDR_WBITS = 64
);
  localparam int DATA_WBYTS = DATA_WBITS / 8;

  logic [ADDR_WBITS+7:0] cmd_tdata;
  logic                  cmd_tvalid;
  logic                  cmd_tready;

  logic [DATA_WBITS-1:0] data_tdata;
  logic [DATA_WBYTS-1:0] data_tkeep;
  logic                  data_tvalid;
  logic                  data_tready;

  logic [DATA_WBITS-1:0] rdmx_tdata;
  logic [DATA_WBYTS-1:0] rdmx_tkeep;
  logic                  rdmx_tvalid;
  logic                  rdmx_tlast;
  logic                  rdmx_tready;

  modport master (
    output cmd_tdata, cmd_tvalid, input cmd_tready,
    output data_tdata, data_tkeep, data_tvalid, input data_tready,
    input rdmx_tdata, rdmx_tkeep, rdmx_tvalid, rdmx_tlast, output rdmx_tready
  );

  modport slave (
    input cmd_tdata, cmd_tvalid, output cmd_tready,
    input data_tdata, data_tkeep, data_tvalid, output data_tready,
    output rdmx_tdata, rdmx_tkeep, rdmx_tvalid, rdmx_tlast, input rdmx_tready
  );
endinterface

// File: rtl/rdmx_xmit_hdr_build.sv
// Combinational builder for the 64-byte Ethernet/IPv4/UDP/RDMX header beat.
// Byte 0 of the wire header lands in hdr[7:0].
module rdmx_hdr_build
  import rdmx_pkg::*;
#(
  parameter logic [47:0] DST_MAC    = 48'h0,
  parameter logic [47:0] SRC_MAC    = 48'h0,
  parameter logic [31:0] SRC_IP     = 32'h0A010101,
  parameter logic [31:0] DST_IP     = 32'h0A010102,
  parameter logic [15:0] SRC_PORT   = 16'd32002,
  parameter logic [15:0] DST_PORT   = 16'd32002,
  parameter logic [15:0] RDMX_MAGIC = 16'h0122
) (
  input  logic [63:0]  addr,
  input  logic [7:0]   len,
  input  logic [15:0]  csum,
  output logic [511:0] hdr
);

  logic [511:0] hdr_be;
  logic [15:0]  udp_len;
  logic [15:0]  ip_len;

  always_comb begin
    udp_len = udp_len_of(len);
    ip_len  = ip_len_of(len);
    // Network order: the first wire byte sits in the top byte of hdr_be.
    hdr_be = {
      DST_MAC, SRC_MAC, ETH_TYPE_IPV4,
      IP4_VER_IHL_TOS, ip_len, IP4_ID, IP4_FLAGS_FRAG, IP4_TTL_PROTO,
      csum, SRC_IP, DST_IP,
      SRC_PORT, DST_PORT, udp_len, UDP_CSUM_NONE,
      RDMX_MAGIC, addr, 96'h0
    };
    for (int i = 0; i < HDR_BYTES; i++) begin
      hdr[8*i +: 8] = hdr_be[511-8*i -: 8];
    end
  end

endmodule

// File: rtl/rdmx_xmit.sv
// RDMX packet transmitter: one header beat per command, then the command's
// data beats passed straight through with TLAST on the final one.
module rdmx_xmit
  import rdmx_pkg::*;
#(
  parameter int          DATA_WBITS = 512,
  parameter int          DATA_WBYTS = DATA_WBITS / 8,
  parameter int          ADDR_WBITS = 64,
  parameter logic [47:0] DST_MAC    = 48'h0,
  parameter logic [47:0] SRC_MAC    = 48'h0,
  parameter logic [31:0] SRC_IP     = 32'h0A010101,
  parameter logic [31:0] DST_IP     = 32'h0A010102,
  parameter logic [15:0] SRC_PORT   = 16'd32002,
  parameter logic [15:0] DST_PORT   = 16'd32002,
  parameter logic [15:0] RDMX_MAGIC = 16'h0122
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic [63:0]           packets_sent,
  output state_t                dbg_state,

  input  logic [ADDR_WBITS+7:0] AXIS_CMD_TDATA,
  input  logic                  AXIS_CMD_TVALID,
  output logic                  AXIS_CMD_TREADY,

  input  logic [DATA_WBITS-1:0] AXIS_DATA_TDATA,
  input  logic [DATA_WBYTS-1:0] AXIS_DATA_TKEEP,
  input  logic                  AXIS_DATA_TVALID,
  output logic                  AXIS_DATA_TREADY,

  output logic [DATA_WBITS-1:0] AXIS_RDMX_TDATA,
  output logic [DATA_WBYTS-1:0] AXIS_RDMX_TKEEP,
  output logic                  AXIS_RDMX_TVALID,
  output logic                  AXIS_RDMX_TLAST,
  input  logic                  AXIS_RDMX_TREADY
);

  state_t                state_q, state_d;
  logic [ADDR_WBITS-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [15:0]           csum_q, csum_d;
  logic [63:0]           pkts_q, pkts_d;
  logic [511:0]          hdr_w;
  logic                  data_hs;

  rdmx_hdr_build #(
    .DST_MAC    (DST_MAC),
    .SRC_MAC    (SRC_MAC),
    .SRC_IP     (SRC_IP),
    .DST_IP     (DST_IP),
    .SRC_PORT   (SRC_PORT),
    .DST_PORT   (DST_PORT),
    .RDMX_MAGIC (RDMX_MAGIC)
  ) u_hdr_build (
    .addr (addr_q),
    .len  (len_q),
    .csum (csum_q),
    .hdr  (hdr_w)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_STARTING;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      pkts_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      pkts_q  <= pkts_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    pkts_d  = pkts_q;

    AXIS_CMD_TREADY  = 1'b0;
    AXIS_DATA_TREADY = 1'b0;
    AXIS_RDMX_TDATA  = '0;
    AXIS_RDMX_TKEEP  = '0;
    AXIS_RDMX_TVALID = 1'b0;
    AXIS_RDMX_TLAST  = 1'b0;
    data_hs          = AXIS_DATA_TVALID && AXIS_RDMX_TREADY;

    unique case (state_q)
      ST_STARTING: state_d = ST_IDLE;

      ST_IDLE: begin
        AXIS_CMD_TREADY = 1'b1;
        if (AXIS_CMD_TVALID) begin
          addr_d  = AXIS_CMD_TDATA[ADDR_WBITS-1:0];
          len_d   = AXIS_CMD_TDATA[ADDR_WBITS+7:ADDR_WBITS];
          cnt_d   = AXIS_CMD_TDATA[ADDR_WBITS+7:ADDR_WBITS];
          state_d = ST_CSUM;
        end
      end

      // Registering the checksum keeps the adder tree off the header path.
      ST_CSUM: begin
        csum_d  = ip4_csum(ip_len_of(len_q), SRC_IP, DST_IP);
        state_d = ST_HDR;
      end

      ST_HDR: begin
        AXIS_RDMX_TDATA  = hdr_w;
        AXIS_RDMX_TKEEP  = '1;
        AXIS_RDMX_TVALID = 1'b1;
        if (AXIS_RDMX_TREADY) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        AXIS_RDMX_TDATA  = AXIS_DATA_TDATA;
        AXIS_RDMX_TKEEP  = AXIS_DATA_TKEEP;
        AXIS_RDMX_TVALID = AXIS_DATA_TVALID;
        AXIS_RDMX_TLAST  = (cnt_q == 8'd0);
        AXIS_DATA_TREADY = AXIS_RDMX_TREADY;
        if (data_hs) begin
          if (cnt_q == 8'd0) begin
            pkts_d  = pkts_q + 64'd1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign packets_sent = pkts_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_rdmx_xmit.sv
// Directed bench for rdmx_xmit: table of packet vectors plus hand-written
// reset and back-to-back sequences.
module tb_rdmx_xmit;
  import rdmx_pkg::*;

  typedef struct {
    logic [7:0]  len;
    logic [63:0] addr;
    logic        rand_rdy;
    int          stall_lo;
    int          stall_hi;
    logic [63:0] last_keep;
    logic [15:0] exp_ip_len;
    logic [15:0] exp_udp_len;
    logic [15:0] exp_csum;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rdmx_xmit_if bus ();
  logic [63:0] packets_sent;
  state_t      dbg_state;

  rdmx_xmit dut (
    .clk              (clk),
    .resetn           (resetn),
    .packets_sent     (packets_sent),
    .dbg_state        (dbg_state),
    .AXIS_CMD_TDATA   (bus.cmd_tdata),
    .AXIS_CMD_TVALID  (bus.cmd_tvalid),
    .AXIS_CMD_TREADY  (bus.cmd_tready),
    .AXIS_DATA_TDATA  (bus.data_tdata),
    .AXIS_DATA_TKEEP  (bus.data_tkeep),
    .AXIS_DATA_TVALID (bus.data_tvalid),
    .AXIS_DATA_TREADY (bus.data_tready),
    .AXIS_RDMX_TDATA  (bus.rdmx_tdata),
    .AXIS_RDMX_TKEEP  (bus.rdmx_tkeep),
    .AXIS_RDMX_TVALID (bus.rdmx_tvalid),
    .AXIS_RDMX_TLAST  (bus.rdmx_tlast),
    .AXIS_RDMX_TREADY (bus.rdmx_tready)
  );

  int          total = 0;
  int          bad = 0;
  int          exp_pkts = 0;
  logic        rand_rdy = 1'b0;
  logic [575:0] exp_q[$];
  vec_t        vecs[5];

  task automatic chk(input string name, input logic [639:0] got, input logic [639:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string what);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for handshake", what);
  endtask

  function automatic logic [15:0] be16(input logic [511:0] b, input int off);
    return {b[8*off +: 8], b[8*off+8 +: 8]};
  endfunction

  function automatic logic [31:0] be32(input logic [511:0] b, input int off);
    return {be16(b, off), be16(b, off + 2)};
  endfunction

  function automatic logic [63:0] be64(input logic [511:0] b, input int off);
    return {be32(b, off), be32(b, off + 4)};
  endfunction

  // Downstream ready: always high, or a coin flip per cycle.
  initial begin
    bus.rdmx_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.rdmx_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_cmd(input logic [7:0] len, input logic [63:0] addr, output int hs_cyc);
    logic hs;
    int   guard;
    hs = 1'b0;
    guard = 0;
    hs_cyc = -1;
    bus.cmd_tdata  = {len, addr};
    bus.cmd_tvalid = 1'b1;
    while (!hs && guard < 3000) begin
      @(negedge clk);
      hs = bus.cmd_tvalid && bus.cmd_tready;
      if (hs) hs_cyc = cyc;
      @(posedge clk);
      #1;
      guard++;
    end
    bus.cmd_tvalid = 1'b0;
    if (!hs) timeout_fail("cmd");
  endtask

  task automatic drive_data(input int n, input int stall_lo, input int stall_hi,
                            input logic [63:0] last_keep);
    logic [511:0] d;
    logic         hs;
    int           guard;
    for (int i = 0; i < n; i++) begin
      if (i + 1 >= stall_lo && i + 1 <= stall_hi) begin
        bus.data_tvalid = 1'b0;
        for (int s = 0; s < 2; s++) begin
          @(negedge clk);
          chk("stall_tvalid", 640'(bus.rdmx_tvalid), 640'(0));
          chk("stall_state", 640'(dbg_state), 640'(ST_DATA));
          @(posedge clk);
          #1;
        end
      end
      for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom();
      bus.data_tdata  = d;
      bus.data_tkeep  = (i == n - 1) ? last_keep : '1;
      bus.data_tvalid = 1'b1;
      exp_q.push_back({bus.data_tkeep, d});
      hs = 1'b0;
      guard = 0;
      while (!hs && guard < 3000) begin
        @(negedge clk);
        hs = bus.data_tvalid && bus.data_tready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!hs) begin
        timeout_fail("data");
        i = n;
      end
    end
    bus.data_tvalid = 1'b0;
  endtask

  task automatic collect_pkt(input int n_data, input vec_t v,
                             output int first_hdr_cyc, output int last_cyc);
    int           idx;
    int           guard;
    logic         prev_stall;
    logic [577:0] prev_beat;
    logic [575:0] e;
    logic [511:0] b;
    idx = 0;
    guard = 0;
    prev_stall = 1'b0;
    prev_beat = '0;
    first_hdr_cyc = -1;
    last_cyc = -1;
    while (idx <= n_data && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (prev_stall)
        chk("stall_hold", 640'({bus.rdmx_tvalid, bus.rdmx_tlast, bus.rdmx_tkeep, bus.rdmx_tdata}),
            640'(prev_beat));
      if (idx == 0 && bus.rdmx_tvalid && first_hdr_cyc < 0) first_hdr_cyc = cyc;
      if (bus.rdmx_tvalid && bus.rdmx_tready) begin
        b = bus.rdmx_tdata;
        if (idx == 0) begin
          chk("hdr_macs", 640'(b[95:0]), 640'(0));
          chk("hdr_fixed", 640'({be16(b, 12), be16(b, 14), be16(b, 18), be16(b, 20), be16(b, 22)}),
              640'({16'h0800, 16'h4500, 16'h0000, 16'h4000, 16'h4011}));
          chk("ip_len", 640'(be16(b, 16)), 640'(v.exp_ip_len));
          chk("ip_csum", 640'(be16(b, 24)), 640'(v.exp_csum));
          chk("ip_addrs", 640'({be32(b, 26), be32(b, 30)}), 640'({32'h0A010101, 32'h0A010102}));
          chk("udp_ports", 640'({be16(b, 34), be16(b, 36)}), 640'({16'd32002, 16'd32002}));
          chk("udp_len", 640'(be16(b, 38)), 640'(v.exp_udp_len));
          chk("udp_csum_magic", 640'({be16(b, 40), be16(b, 42)}), 640'({16'h0000, 16'h0122}));
          chk("rdmx_addr", 640'(be64(b, 44)), 640'(v.addr));
          chk("hdr_reserved", 640'(b[511:416]), 640'(0));
          chk("hdr_keep", 640'(bus.rdmx_tkeep), 640'(64'hFFFF_FFFF_FFFF_FFFF));
          chk("hdr_tlast", 640'(bus.rdmx_tlast), 640'(0));
        end else if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL data_extra: got beat %0d, expected none queued", idx);
        end else begin
          e = exp_q.pop_front();
          chk("data_beat", 640'({bus.rdmx_tkeep, b}), 640'(e));
          chk("data_tlast", 640'(bus.rdmx_tlast), 640'(idx == n_data));
        end
        if (idx == n_data) last_cyc = cyc;
        idx++;
      end
      prev_stall = bus.rdmx_tvalid && !bus.rdmx_tready;
      prev_beat  = {bus.rdmx_tvalid, bus.rdmx_tlast, bus.rdmx_tkeep, bus.rdmx_tdata};
    end
    if (idx <= n_data) timeout_fail("packet_out");
  endtask

  task automatic run_row(input vec_t v);
    int hs_cyc, hdr_cyc, last_cyc;
    rand_rdy = v.rand_rdy;
    fork
      send_cmd(v.len, v.addr, hs_cyc);
      drive_data(int'(v.len) + 1, v.stall_lo, v.stall_hi, v.last_keep);
      collect_pkt(int'(v.len) + 1, v, hdr_cyc, last_cyc);
    join
    rand_rdy = 1'b0;
    chk("hdr_latency", 640'(hdr_cyc - hs_cyc), 640'(2));
    chk("exp_q_empty", 640'(exp_q.size()), 640'(0));
    exp_pkts++;
    @(negedge clk);
    chk("packets_sent", 640'(packets_sent), 640'(exp_pkts));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   hs1, hs2, f1, l1, f2, l2, n, g;
    logic [511:0] d;

    vecs[0] = '{8'd0,   64'h0000_0001_2345_6780, 1'b0, 0, -1, 64'hFFFF_FFFF_FFFF_FFFF,
                16'h0072, 16'h005E, 16'h2477};
    vecs[1] = '{8'd1,   64'hDEAD_BEEF_0000_1000, 1'b0, 0, -1, 64'h0000_0000_FFFF_FFFF,
                16'h00B2, 16'h009E, 16'h2437};
    vecs[2] = '{8'd7,   64'h0123_4567_89AB_CDEF, 1'b1, 3, 5,  64'hFFFF_FFFF_FFFF_FFFF,
                16'h0232, 16'h021E, 16'h22B7};
    vecs[3] = '{8'd255, 64'hFFFF_FFFF_FFFF_FFC0, 1'b0, 0, -1, 64'hFFFF_FFFF_FFFF_FFFF,
                16'h4032, 16'h401E, 16'hE4B6};
    vecs[4] = '{8'd2,   64'h0000_0000_0000_4000, 1'b0, 0, -1, 64'hFFFF_FFFF_FFFF_FFFF,
                16'h00F2, 16'h00DE, 16'h23F7};

    bus.cmd_tdata   = '0;
    bus.cmd_tvalid  = 1'b0;
    bus.data_tdata  = '0;
    bus.data_tkeep  = '0;
    bus.data_tvalid = 1'b0;

    // Reset values, then the one STARTING cycle before IDLE.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_tready", 640'(bus.cmd_tready), 640'(0));
    chk("rst_data_tready", 640'(bus.data_tready), 640'(0));
    chk("rst_tvalid", 640'(bus.rdmx_tvalid), 640'(0));
    chk("rst_tlast", 640'(bus.rdmx_tlast), 640'(0));
    chk("rst_packets", 640'(packets_sent), 640'(0));
    resetn = 1'b1;
    @(negedge clk);
    chk("starting_state", 640'(dbg_state), 640'(ST_STARTING));
    chk("starting_cmd_tready", 640'(bus.cmd_tready), 640'(0));
    @(negedge clk);
    chk("idle_cmd_tready", 640'(bus.cmd_tready), 640'(1));
    @(posedge clk);
    #1;

    for (int r = 0; r < 4; r++) run_row(vecs[r]);

    // Reset during the fourth output beat of an 8-data-beat packet.
    for (int w = 0; w < 16; w++) d[32*w +: 32] = $urandom();
    bus.data_tdata  = d;
    bus.data_tkeep  = '1;
    bus.data_tvalid = 1'b1;
    send_cmd(vecs[4].len + 8'd5, vecs[4].addr, hs1);
    n = 0;
    g = 0;
    while (n < 3 && g < 100) begin
      @(negedge clk);
      g++;
      if (bus.rdmx_tvalid && bus.rdmx_tready) n++;
    end
    if (n < 3) timeout_fail("pre_reset_beats");
    @(posedge clk);
    #1;
    chk("mid_state_before_rst", 640'(dbg_state), 640'(ST_DATA));
    resetn = 1'b0;
    #1;
    chk("mid_rst_tvalid", 640'(bus.rdmx_tvalid), 640'(0));
    chk("mid_rst_cmd_tready", 640'(bus.cmd_tready), 640'(0));
    chk("mid_rst_data_tready", 640'(bus.data_tready), 640'(0));
    chk("mid_rst_packets", 640'(packets_sent), 640'(0));
    bus.data_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    exp_pkts = 0;

    // Two queued commands; the second is held until the first packet ends.
    fork
      begin
        send_cmd(vecs[1].len, vecs[1].addr, hs1);
        send_cmd(vecs[0].len, vecs[0].addr, hs2);
      end
      begin
        drive_data(2, 0, -1, vecs[1].last_keep);
        drive_data(1, 0, -1, vecs[0].last_keep);
      end
      begin
        collect_pkt(2, vecs[1], f1, l1);
        collect_pkt(1, vecs[0], f2, l2);
      end
    join
    chk("b2b_cmd_after_last", 640'(hs2 - l1), 640'(1));
    chk("b2b_hdr_gap", 640'(f2 - l1), 640'(3));
    @(negedge clk);
    chk("b2b_packets", 640'(packets_sent), 640'(2));
    exp_pkts = 2;
    @(posedge clk);
    #1;

    run_row(vecs[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
